// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parameterized 2R/2W register file with zero register, write bypass, busy scoreboard and debug readout
module regfile_param #(
  parameter int WIDTH    = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    raA,
  input  logic [AW-1:0]    raB,
  output logic [WIDTH-1:0] rdA,
  output logic [WIDTH-1:0] rdB,
  input  logic             w0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             w1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic             mk,
  input  logic [AW-1:0]    mka,
  output logic             busyA,
  output logic             busyB,
  output logic             coll,
  input  logic [AW-1:0]    dbg_a,
  output logic [WIDTH-1:0] dbg_d
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             we0, we1;
  logic             hit0A, hit1A, hit0B, hit1B;
  logic             mkA, mkB;

  assign we0 = w0 && (wa0 != ZR);
  assign we1 = w1 && (wa1 != ZR);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (we0) regs[wa0] <= wd0;
      if (we1) regs[wa1] <= wd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll  <= 1'b0;
      dbg_d <= '0;
    end else begin
      if (we0 && we1 && (wa0 == wa1)) coll <= 1'b1;
      dbg_d <= (dbg_a == ZR) ? '0 : regs[dbg_a];
    end
  end

  // Completing writes clear busy first; a mark at the same address then wins.
  always_comb begin
    busy_nxt = busy;
    if (w0) busy_nxt[wa0] = 1'b0;
    if (w1) busy_nxt[wa1] = 1'b0;
    if (mk) busy_nxt[mka] = 1'b1;
    busy_nxt[ZR] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign hit0A = (BYPASS != 0) && w0 && (wa0 == raA);
  assign hit1A = (BYPASS != 0) && w1 && (wa1 == raA);
  assign hit0B = (BYPASS != 0) && w0 && (wa0 == raB);
  assign hit1B = (BYPASS != 0) && w1 && (wa1 == raB);
  assign mkA   = mk && (mka == raA);
  assign mkB   = mk && (mka == raB);

  always_comb begin
    rdA = regs[raA];
    if (hit1A)      rdA = wd1;
    else if (hit0A) rdA = wd0;
    if (rst || (raA == ZR)) rdA = '0;
    rdB = regs[raB];
    if (hit1B)      rdB = wd1;
    else if (hit0B) rdB = wd0;
    if (rst || (raB == ZR)) rdB = '0;
  end

  assign busyA = !rst && busy[raA] && !((hit0A || hit1A) && !mkA);
  assign busyB = !rst && busy[raB] && !((hit0B || hit1B) && !mkB);

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized self-checking bench for regfile_param against a behavioural model
module tb_regfile_param;

  logic        clk, rst;
  logic [4:0]  raA, raB, wa0, wa1, mka, dbg_a;
  logic        w0, w1, mk;
  logic [63:0] wd0, wd1;
  logic [63:0] rdA, rdB, dbg_d, nb_rdA, nb_rdB, nb_dbg_d;
  logic        busyA, busyB, coll, nb_busyA, nb_busyB, nb_coll;

  logic [3:0]  s_raA, s_raB, s_wa0, s_wa1, s_mka, s_dbg_a;
  logic        s_w0, s_w1, s_mk, s_busyA, s_busyB, s_coll;
  logic [31:0] s_wd0, s_wd1, s_rdA, s_rdB, s_dbg_d;

  int          n_chk = 0;
  int          n_fail = 0;

  logic [63:0] m_reg [32];
  bit          m_busy [32];
  bit          m_coll;
  logic [63:0] m_dbg;
  logic [31:0] sw_exp [16];

  regfile_param u_dut (
    .clk(clk), .rst(rst), .raA(raA), .raB(raB), .rdA(rdA), .rdB(rdB),
    .w0(w0), .wa0(wa0), .wd0(wd0), .w1(w1), .wa1(wa1), .wd1(wd1),
    .mk(mk), .mka(mka), .busyA(busyA), .busyB(busyB), .coll(coll),
    .dbg_a(dbg_a), .dbg_d(dbg_d)
  );

  regfile_param #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .raA(raA), .raB(raB), .rdA(nb_rdA), .rdB(nb_rdB),
    .w0(w0), .wa0(wa0), .wd0(wd0), .w1(w1), .wa1(wa1), .wd1(wd1),
    .mk(mk), .mka(mka), .busyA(nb_busyA), .busyB(nb_busyB), .coll(nb_coll),
    .dbg_a(dbg_a), .dbg_d(nb_dbg_d)
  );

  regfile_param #(.WIDTH(32), .AW(4), .ZERO_REG(0)) u_sw (
    .clk(clk), .rst(rst), .raA(s_raA), .raB(s_raB), .rdA(s_rdA), .rdB(s_rdB),
    .w0(s_w0), .wa0(s_wa0), .wd0(s_wd0), .w1(s_w1), .wa1(s_wa1), .wd1(s_wd1),
    .mk(s_mk), .mka(s_mka), .busyA(s_busyA), .busyB(s_busyB), .coll(s_coll),
    .dbg_a(s_dbg_a), .dbg_d(s_dbg_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (rst || ra == 5'd31) return 64'd0;
    if (byp && w1 && wa1 == ra) return wd1;
    if (byp && w0 && wa0 == ra) return wd0;
    return m_reg[ra];
  endfunction

  function automatic bit exp_busy(input logic [4:0] ra, input bit byp);
    if (rst) return 1'b0;
    if (byp && ((w0 && wa0 == ra) || (w1 && wa1 == ra)) && !(mk && mka == ra)) return 1'b0;
    return m_busy[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 64'd0;
      m_busy[i] = 1'b0;
    end
    m_coll = 1'b0;
    m_dbg = 64'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_clear();
    end else begin
      m_dbg = (dbg_a == 5'd31) ? 64'd0 : m_reg[dbg_a];
      if (w0 && wa0 != 5'd31) m_reg[wa0] = wd0;
      if (w1 && wa1 != 5'd31) m_reg[wa1] = wd1;
      if (w0 && w1 && wa0 == wa1 && wa0 != 5'd31) m_coll = 1'b1;
      if (w0) m_busy[wa0] = 1'b0;
      if (w1) m_busy[wa1] = 1'b0;
      if (mk && mka != 5'd31) m_busy[mka] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("rdA", rdA, exp_rd(raA, 1'b1));
    check("rdB", rdB, exp_rd(raB, 1'b1));
    check("nb_rdA", nb_rdA, exp_rd(raA, 1'b0));
    check("nb_rdB", nb_rdB, exp_rd(raB, 1'b0));
    check("busyA", 64'(busyA), 64'(exp_busy(raA, 1'b1)));
    check("busyB", 64'(busyB), 64'(exp_busy(raB, 1'b1)));
    check("nb_busyA", 64'(nb_busyA), 64'(exp_busy(raA, 1'b0)));
    check("coll", 64'(coll), 64'(m_coll));
    check("nb_coll", 64'(nb_coll), 64'(m_coll));
    check("dbg_d", dbg_d, m_dbg);
    check("nb_dbg_d", nb_dbg_d, m_dbg);
  endtask

  // Inputs change at posedge+1; outputs are checked at +2, before the next edge.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    w0 = 0; w1 = 0; mk = 0;
  endtask

  function automatic logic [4:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 5'($urandom_range(0, 5));
    if (r < 8) return 5'($urandom_range(0, 31));
    return 5'd31;
  endfunction

  initial begin
    rst = 1; idle();
    raA = 0; raB = 0; wa0 = 0; wa1 = 0; mka = 0; dbg_a = 0; wd0 = 0; wd1 = 0;
    s_raA = 0; s_raB = 0; s_wa0 = 0; s_wa1 = 0; s_mka = 0; s_dbg_a = 0;
    s_w0 = 0; s_w1 = 0; s_mk = 0; s_wd0 = 0; s_wd1 = 0;
    model_clear();
    repeat (2) tick();
    rst = 0;

    // same-cycle bypass versus no-bypass visibility
    w0 = 1; wa0 = 3; wd0 = 64'hDEAD; raA = 3;
    #1;
    check("byp_same_cycle", rdA, 64'hDEAD);
    check("nobyp_same_cycle", nb_rdA, 64'd0);
    tick();
    idle();
    #1;
    check("byp_next_cycle", rdA, 64'hDEAD);
    check("nobyp_next_cycle", nb_rdA, 64'hDEAD);
    tick();

    // writes and reads of the zero register
    w0 = 1; wa0 = 31; wd0 = 64'h1234; raB = 31; dbg_a = 31;
    #1;
    check("zero_rdB_pre", rdB, 64'd0);
    tick();
    idle();
    tick();
    check("zero_dbg_post", dbg_d, 64'd0);
    check("zero_no_coll", 64'(coll), 64'd0);

    // write collision: port 1 wins, coll is sticky
    w0 = 1; wa0 = 5; wd0 = 64'hAAAA; w1 = 1; wa1 = 5; wd1 = 64'h5555;
    tick();
    idle(); raA = 5;
    #1;
    check("coll_data", rdA, 64'h5555);
    check("coll_set", 64'(coll), 64'd1);
    repeat (3) tick();
    check("coll_sticky", 64'(coll), 64'd1);

    // scoreboard mark / clear / mark-wins
    mk = 1; mka = 7;
    tick();
    idle(); raA = 7;
    #1;
    check("busy_marked", 64'(busyA), 64'd1);
    w1 = 1; wa1 = 7; wd1 = 64'h77;
    #1;
    check("busy_bypass_clear", 64'(busyA), 64'd0);
    check("nb_busy_still", 64'(nb_busyA), 64'd1);
    tick();
    idle();
    #1;
    check("busy_cleared", 64'(busyA), 64'd0);
    mk = 1; mka = 7; w0 = 1; wa0 = 7; wd0 = 64'h78;
    tick();
    idle();
    #1;
    check("busy_mark_wins", 64'(busyA), 64'd1);
    tick();

    // fill, then reset asynchronously between edges
    for (int i = 0; i < 31; i++) begin
      w0 = 1; wa0 = 5'(i); wd0 = 64'(i) * 64'h0101; raA = 5'(i); dbg_a = 5'(i);
      tick();
    end
    idle(); raA = 30; raB = 12; dbg_a = 20;
    tick();
    w0 = 1; wa0 = 12; wd0 = 64'hFFFF; mk = 1; mka = 12;
    #2;
    rst = 1;
    model_clear();
    #1;
    check("async_rdA", rdA, 64'd0);
    check("async_rdB", rdB, 64'd0);
    check("async_dbg", dbg_d, 64'd0);
    check("async_busy", 64'(busyB), 64'd0);
    check("async_coll", 64'(coll), 64'd0);
    tick();
    rst = 0; idle();
    tick();

    // randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 400; c++) begin
      if (rst) rst = 0;
      w0 = 1'($urandom_range(0, 1)); wa0 = rand_addr(); wd0 = {$urandom, $urandom};
      w1 = 1'($urandom_range(0, 1)); wa1 = rand_addr(); wd1 = {$urandom, $urandom};
      mk = 1'($urandom_range(0, 1)); mka = rand_addr();
      raA = rand_addr(); raB = ($urandom_range(0, 4) == 0) ? raA : rand_addr();
      dbg_a = rand_addr();
      if ($urandom_range(0, 59) == 0) begin
        rst = 1;
        model_clear();
      end
      tick();
    end
    rst = 0; idle();
    tick();

    // narrow instance with register 0 as the zero register
    for (int i = 0; i < 16; i++) begin
      sw_exp[i] = (i == 0) ? 32'd0 : $urandom;
      s_w0 = 1; s_wa0 = 4'(i); s_wd0 = (i == 0) ? 32'hCAFE : sw_exp[i];
      s_mk = 1; s_mka = 4'(i);
      @(posedge clk);
      #1;
    end
    s_w0 = 0; s_mk = 0;
    for (int i = 0; i < 16; i++) begin
      s_raA = 4'(i); s_raB = 4'(15 - i); s_dbg_a = 4'(i);
      @(posedge clk);
      #1;
      check("sw_rdA", 64'(s_rdA), 64'(sw_exp[i]));
      check("sw_rdB", 64'(s_rdB), 64'(sw_exp[15 - i]));
      check("sw_busyA", 64'(s_busyA), (i == 0) ? 64'd0 : 64'd1);
      check("sw_dbg", 64'(s_dbg_d), 64'(sw_exp[i]));
    end
    check("sw_coll", 64'(s_coll), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 64: data width of every register and data port in bits.
REQ-002 Parameter AW, default 5: address width; DEPTH = 2**AW registers.
REQ-003 Parameter ZERO_REG, default 31: index of the register that is hardwired to zero.
REQ-004 Parameter BYPASS, default 1: 1 enables same-cycle write-to-read forwarding; 0 disables it.
REQ-005 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-006 Port rst  in  1: asynchronous, active-high reset.
REQ-007 Port raA  in  AW: read address, port A.
REQ-008 Port raB  in  AW: read address, port B.
REQ-009 Port rdA  out  WIDTH: read data, port A.
REQ-010 Port rdB  out  WIDTH: read data, port B.
REQ-011 Port w0 / wa0 / wd0  in  1 / AW / WIDTH: write port 0 enable, address, data.
REQ-012 Port w1 / wa1 / wd1  in  1 / AW / WIDTH: write port 1 enable, address, data.
REQ-013 Port mk / mka  in  1 / AW: scoreboard mark enable and address (register has a write in flight).
REQ-014 Port busyA / busyB  out  1: scoreboard status for raA / raB.
REQ-015 Port coll  out  1: sticky flag, both write ports hit the same non-zero address in one cycle.
REQ-016 Port dbg_a / dbg_d  in AW / out WIDTH: debug address and registered debug readout.

Function
REQ-017 Storage: DEPTH-1 writable WIDTH-bit registers; index ZERO_REG holds no state and always reads 0.
REQ-018 Writes: at the rising edge, reg[wa0] <= wd0 if w0; reg[wa1] <= wd1 if w1; writes to ZERO_REG are ignored.
REQ-019 Write collision: w0 & w1 & wa0==wa1 != ZERO_REG -> port 1 data is stored; coll sets to 1 at that edge and holds until reset.
REQ-020 Reads are combinational: rdX = reg[raX]; rdX = 0 whenever raX == ZERO_REG, regardless of bypass.
REQ-021 BYPASS=1: if w1 & wa1==raX then rdX = wd1; else if w0 & wa0==raX then rdX = wd0; else stored value (zero reg excepted).
REQ-022 BYPASS=0: rdX shows the stored value; a write becomes visible on the cycle after its edge.
REQ-023 Scoreboard: DEPTH-entry busy vector; busy[ZERO_REG] is constant 0.
REQ-024 At the edge: busy[wa0] cleared if w0, busy[wa1] cleared if w1, then busy[mka] set if mk (mark wins over clear at the same address).
REQ-025 busyX = busy[raX], forced 0 when BYPASS=1 and a write enable targets raX in the current cycle, unless mk also targets raX.
REQ-026 mk to ZERO_REG has no effect; marking an already-busy register leaves it busy.
REQ-027 Debug: dbg_d <= (dbg_a==ZERO_REG) ? 0 : reg[dbg_a] each edge, pre-write value (1-cycle latency, no bypass).
REQ-028 Two read ports are fully independent; raA==raB returns identical data and busy values.

Reset
REQ-029 rst high asynchronously clears all registers, all busy bits, coll and dbg_d to 0, independent of clk.
REQ-030 While rst is high, writes and marks are ignored; rdA/rdB read 0 and busyA/busyB read 0.
REQ-031 Reset asserted mid-operation (pending marks, same-cycle writes) discards them; first edge after rst deasserts operates normally.

Verification
REQ-032 Reset, then w0=1 wa0=3 wd0=0xDEAD, raA=3 same cycle -> rdA=0xDEAD (BYPASS=1); next cycle, w0=0 -> rdA=0xDEAD; with BYPASS=0, rdA=0 in the write cycle.
REQ-033 w0 wa0=31 wd0=0x1234, raB=31, dbg_a=31 -> rdB=0, dbg_d=0 before and after the edge; coll stays 0.
REQ-034 w0 wa0=5 wd0=0xAAAA and w1 wa1=5 wd1=0x5555 in one cycle -> next cycle raA=5 reads 0x5555, coll=1 and stays 1 until rst.
REQ-035 mk mka=7 -> busyA=1 for raA=7 next cycle; w1 wa1=7 next cycle -> busyA=0 in that cycle (bypass) and after the edge; mk and w0 both at 7 together -> busy remains 1.
REQ-036 Fill registers 0..30 with value index*0x0101, assert rst asynchronously between edges -> all rd and dbg_d read 0 immediately; busy and coll are 0.
REQ-037 Parameter sweep WIDTH=32 AW=4 ZERO_REG=0 -> reg 0 reads 0, regs 1..15 write and read back, busy[0] never asserts.
